// File: rtl/fifo_pkg.sv
// Shared types and constants for the async-FIFO read-side packer.
// Holds default widths, the lane/beat typedefs and a width helper.
package fifo_pkg;

  localparam int DATASIZE_DEF = 8;
  localparam int PACK_DEF     = 4;
  localparam int PACK_MAX     = 16;

  typedef logic [$clog2(PACK_DEF)-1:0] lane_t;

  typedef struct packed {
    logic [PACK_DEF-1:0]              keep;
    logic [DATASIZE_DEF*PACK_DEF-1:0] data;
  } beat_t;

  localparam logic [PACK_MAX-1:0] KEEP_ALL = '1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int lane_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_rd_idle_timer.sv
// Idle counter for the packer: counts cycles without a pop while a
// partial beat is pending and strobes o_expire when it may be flushed.
// Ports: clk/rst, i_active (partial pending), i_pop, i_free, o_expire.
module fifo_rd_idle_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_pop,
  input  logic i_free,
  output logic o_expire
);

  localparam int IW = lane_w(TIMEOUT);

  logic [IW-1:0] r_idle;
  logic          w_at_max;

  assign w_at_max = r_idle == IW'(TIMEOUT - 1);

  // A pop in the expiry cycle wins over the flush.
  assign o_expire = i_active && !i_pop && w_at_max && i_free;

  // Saturates at TIMEOUT-1 while the output register is busy.
  always_ff @(posedge clk) begin
    if (rst || !i_active || i_pop || o_expire) begin
      r_idle <= '0;
    end else if (!w_at_max) begin
      r_idle <= r_idle + IW'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops narrow FIFO words and packs PACK of them into one valid/ready beat.
// Ports: rclk/rrst, FIFO read side (rdata, rempty, rinc), output stream
// (out_data, out_keep, out_valid, out_ready). Optional partial-beat flush
// on idle timeout is enabled by defining FIFO_RD_PACK_FLUSH_EN.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DATASIZE_DEF,
  parameter int PACK     = PACK_DEF,
  parameter int TIMEOUT  = 16
) (
  input  logic                     rclk,
  input  logic                     rrst,
  input  logic [DATASIZE-1:0]      rdata,
  input  logic                     rempty,
  output logic                     rinc,
  output logic [DATASIZE*PACK-1:0] out_data,
  output logic [PACK-1:0]          out_keep,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int LW = lane_w(PACK);

  if (PACK < 2 || PACK > PACK_MAX) begin : g_bad_pack
    $error("fifo_rd_packer: PACK out of range");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("fifo_rd_packer: TIMEOUT too small");
  end

  logic [LW-1:0]                   r_lane;
  logic [PACK-2:0][DATASIZE-1:0]   r_asm;
  logic [DATASIZE*PACK-1:0]        r_data;
  logic [PACK-1:0]                 r_keep;
  logic                            r_valid;

  logic w_last;
  logic w_stall;
  logic w_accept;

  assign w_last   = r_lane == LW'(PACK - 1);
  // Only the final word needs the output register; earlier ones never stall.
  assign w_stall  = w_last && r_valid && !out_ready;
  assign w_accept = r_valid && out_ready;
  assign rinc     = !rrst && !rempty && !w_stall;

  assign out_data  = r_data;
  assign out_keep  = r_keep;
  assign out_valid = r_valid;

`ifdef FIFO_RD_PACK_FLUSH_EN
  logic                     w_expire;
  logic [DATASIZE*PACK-1:0] w_flush_data;
  logic [PACK-1:0]          w_flush_keep;

  fifo_rd_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle (
    .clk      (rclk),
    .rst      (rrst),
    .i_active (r_lane != '0),
    .i_pop    (rinc),
    .i_free   (!r_valid || out_ready),
    .o_expire (w_expire)
  );

  // Stale lanes from an earlier beat are masked to zero.
  always_comb begin
    w_flush_data = '0;
    w_flush_keep = '0;
    for (int i = 0; i < PACK - 1; i++) begin
      if (LW'(i) < r_lane) begin
        w_flush_data[i*DATASIZE +: DATASIZE] = r_asm[i];
        w_flush_keep[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge rclk) begin
    if (rrst) begin
      r_lane  <= '0;
      r_asm   <= '0;
      r_data  <= '0;
      r_keep  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b0;
      end
      if (rinc) begin
        if (w_last) begin
          // Overrides the clear above: back-to-back beats, no bubble.
          r_data  <= {rdata, r_asm};
          r_keep  <= KEEP_ALL[PACK-1:0];
          r_valid <= 1'b1;
          r_lane  <= '0;
        end else begin
          for (int i = 0; i < PACK - 1; i++) begin
            if (LW'(i) == r_lane) begin
              r_asm[i] <= rdata;
            end
          end
          r_lane <= r_lane + LW'(1);
        end
      end
`ifdef FIFO_RD_PACK_FLUSH_EN
      else if (w_expire) begin
        r_data  <= w_flush_data;
        r_keep  <= w_flush_keep;
        r_valid <= 1'b1;
        r_lane  <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed and random checks for fifo_rd_packer (DATASIZE=8, PACK=4).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic [7:0]  rdata = '0;
  logic        rempty = 1'b1;
  logic        rinc;
  logic [31:0] out_data;
  logic [3:0]  out_keep;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(
    .DATASIZE (8),
    .PACK     (4),
    .TIMEOUT  (16)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .rdata     (rdata),
    .rempty    (rempty),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        rst;
    logic        empty;
    logic [7:0]  d;
    logic        rdy;
    logic        erinc;
    logic        chk;
    logic        evalid;
    logic [31:0] edata;
    logic [3:0]  ekeep;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic r, e, input logic [7:0] d, input logic rdy,
    input logic erinc, c, ev, input logic [31:0] ed,
    input logic [3:0] ek);
    vec_t v;
    v.rst = r; v.empty = e; v.d = d; v.rdy = rdy;
    v.erinc = erinc; v.chk = c; v.evalid = ev;
    v.edata = ed; v.ekeep = ek;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, input logic [7:0] d,
                       input logic rdy);
    rrst = r; rempty = e; rdata = d; out_ready = rdy;
    #1;
  endtask

  task automatic tick;
    @(posedge rclk);
    @(negedge rclk);
  endtask

  logic [7:0] words [1000];
  int pi, bi, ez, rz, cyc;
  logic e, r;
  logic [31:0] exp_beat;

  initial begin
    // reset
    tv.push_back(mk(1,0,8'h55,0, 0,0,0,32'h0,4'h0));
    tv.push_back(mk(1,0,8'h55,0, 0,1,0,32'h0,4'h0));
    tv.push_back(mk(1,0,8'h55,0, 0,1,0,32'h0,4'h0));
    // back-to-back packing
    tv.push_back(mk(0,0,8'h11,1, 1,1,0,32'h0,4'h0));
    tv.push_back(mk(0,0,8'h22,1, 1,1,0,32'h0,4'h0));
    tv.push_back(mk(0,0,8'h33,1, 1,1,0,32'h0,4'h0));
    tv.push_back(mk(0,0,8'h44,1, 1,1,0,32'h0,4'h0));
    tv.push_back(mk(0,1,8'h00,1, 0,1,1,32'h44332211,4'hF));
    tv.push_back(mk(0,1,8'h00,1, 0,1,0,32'h44332211,4'hF));
    // backpressure
    tv.push_back(mk(0,0,8'h01,0, 1,1,0,32'h44332211,4'hF));
    tv.push_back(mk(0,0,8'h02,0, 1,1,0,32'h44332211,4'hF));
    tv.push_back(mk(0,0,8'h03,0, 1,1,0,32'h44332211,4'hF));
    tv.push_back(mk(0,0,8'h04,0, 1,1,0,32'h44332211,4'hF));
    tv.push_back(mk(0,0,8'h05,0, 1,1,1,32'h04030201,4'hF));
    tv.push_back(mk(0,0,8'h06,0, 1,1,1,32'h04030201,4'hF));
    tv.push_back(mk(0,0,8'h07,0, 1,1,1,32'h04030201,4'hF));
    tv.push_back(mk(0,0,8'h08,0, 0,1,1,32'h04030201,4'hF));
    tv.push_back(mk(0,0,8'h08,0, 0,1,1,32'h04030201,4'hF));
    tv.push_back(mk(0,0,8'h08,1, 1,1,1,32'h04030201,4'hF));
    tv.push_back(mk(0,1,8'h00,1, 0,1,1,32'h08070605,4'hF));
    tv.push_back(mk(0,1,8'h00,1, 0,1,0,32'h08070605,4'hF));

    @(negedge rclk);
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].empty, tv[i].d, tv[i].rdy);
      chk($sformatf("v%0d_rinc", i), 32'(rinc), 32'(tv[i].erinc));
      if (tv[i].chk) begin
        chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tv[i].evalid));
        chk($sformatf("v%0d_data", i), out_data, tv[i].edata);
        chk($sformatf("v%0d_keep", i), 32'(out_keep), 32'(tv[i].ekeep));
      end
      tick();
    end

    // partial beat: flush after timeout, or never without the feature
    drive(0, 0, 8'hAA, 1); tick();
    drive(0, 0, 8'hBB, 1); tick();
    for (int k = 1; k <= 40; k++) begin
      drive(0, 1, 8'h00, 1);
`ifdef FIFO_RD_PACK_FLUSH_EN
      chk($sformatf("flush_valid_k%0d", k), 32'(out_valid),
          32'(k == 17));
      if (k == 17) begin
        chk("flush_data", out_data, 32'h0000BBAA);
        chk("flush_keep", 32'(out_keep), 32'h3);
      end
`else
      chk($sformatf("noflush_valid_k%0d", k), 32'(out_valid), 32'h0);
`endif
      tick();
    end

    // reset mid-operation: lane=2 with a beat pending
    drive(1, 1, 8'h00, 0); tick();
    drive(0, 0, 8'hC1, 0); tick();
    drive(0, 0, 8'hC2, 0); tick();
    drive(0, 0, 8'hC3, 0); tick();
    drive(0, 0, 8'hC4, 0); tick();
    drive(0, 0, 8'hD1, 0); tick();
    drive(0, 0, 8'hD2, 0);
    chk("mid_pre_rinc", 32'(rinc), 32'h1);
    tick();
    drive(1, 0, 8'hD3, 0);
    chk("mid_pend_valid", 32'(out_valid), 32'h1);
    chk("mid_pend_data", out_data, 32'hC4C3C2C1);
    chk("mid_rst_rinc", 32'(rinc), 32'h0);
    tick();
    drive(0, 1, 8'h00, 1);
    chk("mid_clr_valid", 32'(out_valid), 32'h0);
    chk("mid_clr_data", out_data, 32'h0);
    chk("mid_clr_keep", 32'(out_keep), 32'h0);
    tick();
    drive(0, 0, 8'hE1, 1); tick();
    drive(0, 0, 8'hE2, 1); tick();
    drive(0, 0, 8'hE3, 1); tick();
    drive(0, 0, 8'hE4, 1); tick();
    drive(0, 1, 8'h00, 1);
    chk("mid_new_valid", 32'(out_valid), 32'h1);
    chk("mid_new_data", out_data, 32'hE4E3E2E1);
    chk("mid_new_keep", 32'(out_keep), 32'hF);
    tick();

    // random traffic with a lossless, ordered scoreboard
    for (int i = 0; i < 1000; i++) words[i] = 8'($urandom);
    pi = 0; bi = 0; ez = 0; rz = 0; cyc = 0;
    while (bi < 1000 && cyc < 20000) begin
      if (pi >= 1000) e = 1'b1;
      else e = ($urandom_range(0, 2) == 0) && (ez < 3);
      ez = e ? ez + 1 : 0;
      r = ($urandom_range(0, 2) != 0) || (rz >= 3);
      rz = r ? 0 : rz + 1;
      drive(0, e, (pi < 1000) ? words[pi] : 8'hEE, r);
      chk("rand_rinc_empty", 32'(rinc && rempty), 32'h0);
      if (out_valid && out_ready) begin
        exp_beat = {words[bi+3], words[bi+2], words[bi+1], words[bi]};
        chk($sformatf("rand_data_b%0d", bi / 4), out_data, exp_beat);
        chk($sformatf("rand_keep_b%0d", bi / 4), 32'(out_keep), 32'hF);
        bi += 4;
      end
      if (rinc) pi++;
      tick();
      cyc++;
    end
    chk("rand_words_out", 32'(bi), 32'd1000);
    chk("rand_words_popped", 32'(pi), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
